pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control unit for the rv32i core. Collects stall requests from IF, ID, EXE and MEM plus jump requests from EXE, and drives the 6-bit stall vector and the jump-flush / PC-redirect signals consumed by the PC, if_id, id_exe, exe_mem and mem_wb stages. It also sequences multi-cycle flushes, defers jumps that arrive while the pipe is frozen, and watches for stuck stalls.

## Interface
- FLUSH_CYCLES, 2: cycles jump_flush_out stays high per accepted jump (1..15)
- STALL_TIMEOUT, 1024: consecutive stalled cycles that trip the watchdog (1..65535)

- clk_in  input  1  core clock
- reset_in  input  1  asynchronous, active-high reset
- if_stall_req_in  input  1  instruction bus not ready
- id_stall_req_in  input  1  load-use hazard detected in ID
- exe_stall_req_in  input  1  multi-cycle EXE op busy
- mem_stall_req_in  input  1  data bus not ready
- jump_req_in  input  1  EXE resolved a taken branch/jump
- jump_addr_in  input  32  target address for jump_req_in
- stall_out  output  6  bit0 PC, 1 IF, 2 ID, 3 EXE, 4 MEM, 5 WB; `STOP`=1, `NOSTOP`=0
- jump_flush_out  output  1  flush IF/ID and ID/EXE contents
- jump_out  output  1  one-cycle PC load strobe
- jump_addr_out  output  32  PC load value, valid with jump_out
- stall_timeout_out  output  1  sticky watchdog flag
- stall_cycles_out  output  32  perf: cycles with stall_out != 0
- jump_count_out  output  32  perf: accepted jumps

## Operation
- FSM states: RUN, PEND, FLUSH. Registers: state, 4-bit flush counter, 32-bit latched target, 16-bit stall counter, sticky flag.
- stall_out is combinational, first match wins:
  - mem_stall_req_in -> 6'b011111
  - exe_stall_req_in -> 6'b001111
  - id_stall_req_in -> 6'b000111 (ID held, EXE runs: id_exe inserts bubble)
  - if_stall_req_in -> 6'b000011
  - else 6'b000000
- In FLUSH, id/if requests are masked (those instructions are dead); mem/exe still apply. In PEND, all requests apply.
- RUN: jump_req_in with stall_out[3]=`NOSTOP` -> latch jump_addr_in, load counter with FLUSH_CYCLES, go FLUSH. jump_req_in with stall_out[3]=`STOP` -> latch target, go PEND.
- PEND: jump_req_in ignored. When mem_stall_req_in=0 and exe_stall_req_in=0 -> load counter, go FLUSH.
- FLUSH: jump_flush_out=1 every cycle. jump_out=1 only in the first FLUSH cycle; jump_addr_out = latched target always. Counter decrements on cycles with stall_out[3]=`NOSTOP`, holds otherwise. When it decrements to 0 -> RUN. jump_req_in ignored.
- Watchdog: stall counter increments while stall_out != 0 and clears when stall_out == 0. It saturates at STALL_TIMEOUT; on reaching it, stall_timeout_out sets and stays set until reset.

## Timing
- Reset (asynchronous): state RUN, counters 0, latched target 0, stall_timeout_out 0. While reset_in=1, stall_out=0, jump_flush_out=0, jump_out=0 (gated). Reset mid-FLUSH/PEND drops the pending jump.
- Accepted jump: jump_req_in at cycle N -> jump_out and jump_flush_out at N+1. jump_flush_out stays high through N+FLUSH_CYCLES if unstalled.
- Deferred jump: jump_out occurs one cycle after the first cycle with mem and exe requests both low.
- Simultaneous jump_req_in and id_stall_req_in in RUN: jump wins. It is accepted because stall_out[3]=`NOSTOP`, and the load-use stall is masked from the next cycle.
- Watchdog trips in the cycle after the STALL_TIMEOUT-th consecutive stalled cycle.

## Configuration
- PIPE_CTRL_PERF_EN defined: stall_cycles_out increments each cycle with stall_out != 0. jump_count_out increments on each RUN/PEND->FLUSH transition. Both wrap modulo 2^32 and reset to 0.
- Undefined: both counters are absent and the ports are driven constant 0. All other behaviour is identical.

## Test plan
- id_stall_req_in=1 for 1 cycle, no other requests -> stall_out=6'b000111 that cycle, then 0; no flush.
- jump_req_in=1, jump_addr_in=32'h0000_0100 in RUN, FLUSH_CYCLES=2 -> next cycle jump_out=1, jump_addr_out=32'h100; jump_flush_out high exactly 2 cycles, then RUN.
- mem_stall_req_in high 3 cycles with jump_req_in in the first, addr 32'h200 -> stall_out=6'b011111 for 3 cycles; jump_out=1 with 32'h200 on the cycle after mem_stall drops; jump_count_out=1 if PIPE_CTRL_PERF_EN.
- exe_stall_req_in asserted during 2nd FLUSH cycle for 2 cycles -> stall_out=6'b001111, jump_flush_out extends 2 cycles; second jump_req_in during FLUSH ignored.
- STALL_TIMEOUT=4, if_stall_req_in held 5 cycles -> stall_timeout_out rises after 4th stalled cycle, stays 1 after request drops; clears only on reset_in.
- reset_in asserted mid-PEND -> all outputs 0 immediately; after release no jump_out is issued.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline control unit for the rv32i core.
// Merges stall requests from IF/ID/EXE/MEM into the per-stage stall vector,
// turns EXE jump requests into a PC redirect plus a multi-cycle flush, defers
// jumps that arrive while EXE is frozen, and flags stalls that never clear.
// Optional build macro: PIPE_CTRL_PERF_EN enables the stall-cycle and
// accepted-jump performance counters; without it both ports read 0.
//
// state | meaning
// RUN   | normal operation, jump requests accepted
// PEND  | jump latched while EXE/MEM frozen, waiting for them to release
// FLUSH | redirect issued, younger IF/ID/EXE contents being flushed
module pipe_ctrl #(
   parameter int FLUSH_CYCLES  = 2,
   parameter int STALL_TIMEOUT = 1024
) (
   input  logic        clk_in,
   input  logic        reset_in,
   input  logic        if_stall_req_in,
   input  logic        id_stall_req_in,
   input  logic        exe_stall_req_in,
   input  logic        mem_stall_req_in,
   input  logic        jump_req_in,
   input  logic [31:0] jump_addr_in,
   output logic [5:0]  stall_out,
   output logic        jump_flush_out,
   output logic        jump_out,
   output logic [31:0] jump_addr_out,
   output logic        stall_timeout_out,
   output logic [31:0] stall_cycles_out,
   output logic [31:0] jump_count_out
);

   localparam logic [1:0]  ST_RUN   = 2'd0;
   localparam logic [1:0]  ST_PEND  = 2'd1;
   localparam logic [1:0]  ST_FLUSH = 2'd2;

   localparam logic        STOP   = 1'b1;
   localparam logic        NOSTOP = 1'b0;

   localparam logic [3:0]  LP_FLUSH_LOAD = 4'(FLUSH_CYCLES);
   localparam logic [15:0] LP_TIMEOUT    = 16'(STALL_TIMEOUT);

   logic [1:0]  r_state;
   logic [3:0]  r_flush_cnt;
   logic [31:0] r_target;
   logic        r_first;
   logic [15:0] r_stall_cnt;
   logic        r_timeout;

   logic [5:0]  w_stall;
   logic        w_in_flush;
   logic        w_stall_any;
   logic        w_enter_flush;

   assign w_in_flush = (r_state == ST_FLUSH);

   // Priority-encode stall requests; IF/ID requests are dead while flushing.
   always_comb begin
      w_stall = 6'b000000;
      if (reset_in)
         w_stall = 6'b000000;
      else if (mem_stall_req_in)
         w_stall = 6'b011111;
      else if (exe_stall_req_in)
         w_stall = 6'b001111;
      else if (id_stall_req_in && !w_in_flush)
         w_stall = 6'b000111;
      else if (if_stall_req_in && !w_in_flush)
         w_stall = 6'b000011;
   end

   assign w_stall_any = |w_stall;

   // A jump starts flushing either straight from RUN (EXE free) or once PEND sees EXE/MEM release.
   always_comb begin
      w_enter_flush = 1'b0;
      if (r_state == ST_RUN)
         w_enter_flush = jump_req_in && (w_stall[3] == NOSTOP);
      else if (r_state == ST_PEND)
         w_enter_flush = !mem_stall_req_in && !exe_stall_req_in;
   end

   // Jump sequencing FSM: target latch, flush counter and first-cycle marker.
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         r_state     <= ST_RUN;
         r_flush_cnt <= 4'd0;
         r_target    <= 32'd0;
         r_first     <= 1'b0;
      end else begin
         r_first <= 1'b0;
         case (r_state)
            ST_RUN: begin
               if (jump_req_in) begin
                  r_target <= jump_addr_in;
                  if (w_stall[3] == NOSTOP) begin
                     r_state     <= ST_FLUSH;
                     r_flush_cnt <= LP_FLUSH_LOAD;
                     r_first     <= 1'b1;
                  end else begin
                     r_state <= ST_PEND;
                  end
               end
            end
            ST_PEND: begin
               if (w_enter_flush) begin
                  r_state     <= ST_FLUSH;
                  r_flush_cnt <= LP_FLUSH_LOAD;
                  r_first     <= 1'b1;
               end
            end
            ST_FLUSH: begin
               // EXE frozen means the flushed slots have not advanced yet, so hold the count.
               if (w_stall[3] == NOSTOP) begin
                  if (r_flush_cnt <= 4'd1) begin
                     r_flush_cnt <= 4'd0;
                     r_state     <= ST_RUN;
                  end else begin
                     r_flush_cnt <= r_flush_cnt - 4'd1;
                  end
               end
            end
            default: begin
               r_state     <= ST_RUN;
               r_flush_cnt <= 4'd0;
            end
         endcase
      end
   end

   // Watchdog: count consecutive stalled cycles, saturate, latch a sticky flag.
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         r_stall_cnt <= 16'd0;
         r_timeout   <= 1'b0;
      end else begin
         if (!w_stall_any)
            r_stall_cnt <= 16'd0;
         else if (r_stall_cnt != LP_TIMEOUT)
            r_stall_cnt <= r_stall_cnt + 16'd1;
         if (w_stall_any && (r_stall_cnt >= (LP_TIMEOUT - 16'd1)))
            r_timeout <= 1'b1;
      end
   end

   assign stall_out         = w_stall;
   assign jump_flush_out    = w_in_flush && !reset_in;
   assign jump_out          = w_in_flush && r_first && !reset_in;
   assign jump_addr_out     = r_target;
   assign stall_timeout_out = r_timeout;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] r_stall_cycles;
   logic [31:0] r_jump_count;

   // Free-running performance counters, wrapping modulo 2^32.
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         r_stall_cycles <= 32'd0;
         r_jump_count   <= 32'd0;
      end else begin
         if (w_stall_any)
            r_stall_cycles <= r_stall_cycles + 32'd1;
         if (w_enter_flush)
            r_jump_count <= r_jump_count + 32'd1;
      end
   end

   assign stall_cycles_out = r_stall_cycles;
   assign jump_count_out   = r_jump_count;
`else
   assign stall_cycles_out = 32'd0;
   assign jump_count_out   = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl: a cycle-by-cycle vector table followed by
// a hand-written reset-during-PEND sequence.
module tb_pipe_ctrl;

   logic        clk_in;
   logic        reset_in;
   logic        if_stall_req_in;
   logic        id_stall_req_in;
   logic        exe_stall_req_in;
   logic        mem_stall_req_in;
   logic        jump_req_in;
   logic [31:0] jump_addr_in;
   logic [5:0]  stall_out;
   logic        jump_flush_out;
   logic        jump_out;
   logic [31:0] jump_addr_out;
   logic        stall_timeout_out;
   logic [31:0] stall_cycles_out;
   logic [31:0] jump_count_out;

   int n_checks = 0;
   int n_fail   = 0;

   pipe_ctrl #(.FLUSH_CYCLES(2), .STALL_TIMEOUT(4)) u_dut (
      .clk_in            (clk_in),
      .reset_in          (reset_in),
      .if_stall_req_in   (if_stall_req_in),
      .id_stall_req_in   (id_stall_req_in),
      .exe_stall_req_in  (exe_stall_req_in),
      .mem_stall_req_in  (mem_stall_req_in),
      .jump_req_in       (jump_req_in),
      .jump_addr_in      (jump_addr_in),
      .stall_out         (stall_out),
      .jump_flush_out    (jump_flush_out),
      .jump_out          (jump_out),
      .jump_addr_out     (jump_addr_out),
      .stall_timeout_out (stall_timeout_out),
      .stall_cycles_out  (stall_cycles_out),
      .jump_count_out    (jump_count_out)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   typedef struct {
      logic        r_if;
      logic        r_id;
      logic        r_exe;
      logic        r_mem;
      logic        r_jr;
      logic [31:0] addr;
      logic [5:0]  e_stall;
      logic        e_flush;
      logic        e_jump;
      logic [31:0] e_addr;
      logic        e_to;
   } vec_t;

   localparam int NV = 30;
   vec_t vecs[NV];

   function automatic vec_t mk(input logic i_if, input logic i_id, input logic i_exe,
                               input logic i_mem, input logic i_jr, input logic [31:0] i_addr,
                               input logic [5:0] e_st, input logic e_fl, input logic e_j,
                               input logic [31:0] e_a, input logic e_t);
      vec_t v;
      v.r_if = i_if; v.r_id = i_id; v.r_exe = i_exe; v.r_mem = i_mem; v.r_jr = i_jr;
      v.addr = i_addr; v.e_stall = e_st; v.e_flush = e_fl; v.e_jump = e_j;
      v.e_addr = e_a; v.e_to = e_t;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic i_if, input logic i_id, input logic i_exe,
                        input logic i_mem, input logic i_jr, input logic [31:0] i_addr);
      if_stall_req_in  = i_if;
      id_stall_req_in  = i_id;
      exe_stall_req_in = i_exe;
      mem_stall_req_in = i_mem;
      jump_req_in      = i_jr;
      jump_addr_in     = i_addr;
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   logic [31:0] exp_stall_cycles;
   logic [31:0] exp_jump_count;

   initial begin
      // cycle-by-cycle stream; each row is one clock with its inputs and the outputs seen in that cycle
      //             if id ex me jr addr           stall      fl jp e_addr         to
      vecs[0]  = mk(0, 0, 0, 0, 0, 32'h0,        6'b000000, 0, 0, 32'h0,        0);
      vecs[1]  = mk(0, 1, 0, 0, 0, 32'h0,        6'b000111, 0, 0, 32'h0,        0);
      vecs[2]  = mk(0, 0, 0, 0, 0, 32'h0,        6'b000000, 0, 0, 32'h0,        0);
      vecs[3]  = mk(1, 0, 0, 0, 0, 32'h0,        6'b000011, 0, 0, 32'h0,        0);
      vecs[4]  = mk(0, 0, 1, 0, 0, 32'h0,        6'b001111, 0, 0, 32'h0,        0);
      vecs[5]  = mk(0, 1, 1, 1, 0, 32'h0,        6'b011111, 0, 0, 32'h0,        0);
      vecs[6]  = mk(0, 0, 0, 0, 1, 32'h100,      6'b000000, 0, 0, 32'h0,        0);
      vecs[7]  = mk(0, 0, 0, 0, 0, 32'h0,        6'b000000, 1, 1, 32'h100,      0);
      vecs[8]  = mk(0, 0, 0, 0, 0, 32'h0,        6'b000000, 1, 0, 32'h100,      0);
      vecs[9]  = mk(0, 0, 0, 0, 0, 32'h0,        6'b000000, 0, 0, 32'h100,      0);
      vecs[10] = mk(0, 0, 0, 1, 1, 32'h200,      6'b011111, 0, 0, 32'h100,      0);
      vecs[11] = mk(0, 0, 0, 1, 0, 32'h0,        6'b011111, 0, 0, 32'h200,      0);
      vecs[12] = mk(0, 0, 0, 1, 0, 32'h0,        6'b011111, 0, 0, 32'h200,      0);
      vecs[13] = mk(0, 0, 0, 0, 0, 32'h0,        6'b000000, 0, 0, 32'h200,      0);
      vecs[14] = mk(0, 0, 0, 0, 0, 32'h0,        6'b000000, 1, 1, 32'h200,      0);
      vecs[15] = mk(0, 0, 1, 0, 1, 32'h300,      6'b001111, 1, 0, 32'h200,      0);
      vecs[16] = mk(0, 0, 1, 0, 0, 32'h0,        6'b001111, 1, 0, 32'h200,      0);
      vecs[17] = mk(0, 0, 0, 0, 0, 32'h0,        6'b000000, 1, 0, 32'h200,      0);
      vecs[18] = mk(0, 0, 0, 0, 0, 32'h0,        6'b000000, 0, 0, 32'h200,      0);
      vecs[19] = mk(0, 1, 0, 0, 1, 32'h400,      6'b000111, 0, 0, 32'h200,      0);
      vecs[20] = mk(0, 1, 0, 0, 0, 32'h0,        6'b000000, 1, 1, 32'h400,      0);
      vecs[21] = mk(1, 0, 0, 0, 0, 32'h0,        6'b000000, 1, 0, 32'h400,      0);
      vecs[22] = mk(0, 0, 0, 0, 0, 32'h0,        6'b000000, 0, 0, 32'h400,      0);
      vecs[23] = mk(1, 0, 0, 0, 0, 32'h0,        6'b000011, 0, 0, 32'h400,      0);
      vecs[24] = mk(1, 0, 0, 0, 0, 32'h0,        6'b000011, 0, 0, 32'h400,      0);
      vecs[25] = mk(1, 0, 0, 0, 0, 32'h0,        6'b000011, 0, 0, 32'h400,      0);
      vecs[26] = mk(1, 0, 0, 0, 0, 32'h0,        6'b000011, 0, 0, 32'h400,      0);
      vecs[27] = mk(1, 0, 0, 0, 0, 32'h0,        6'b000011, 0, 0, 32'h400,      1);
      vecs[28] = mk(0, 0, 0, 0, 0, 32'h0,        6'b000000, 0, 0, 32'h400,      1);
      vecs[29] = mk(0, 0, 0, 0, 0, 32'h0,        6'b000000, 0, 0, 32'h400,      1);

`ifdef PIPE_CTRL_PERF_EN
      exp_stall_cycles = 32'd15;
      exp_jump_count   = 32'd3;
`else
      exp_stall_cycles = 32'd0;
      exp_jump_count   = 32'd0;
`endif

      reset_in = 1'b1;
      drive(0, 0, 0, 1, 0, 32'h0);
      #3;
      check("reset_stall",   32'(stall_out),         32'h0);
      check("reset_flush",   32'(jump_flush_out),    32'h0);
      check("reset_jump",    32'(jump_out),          32'h0);
      check("reset_addr",    jump_addr_out,          32'h0);
      check("reset_timeout", 32'(stall_timeout_out), 32'h0);
      check("reset_scyc",    stall_cycles_out,       32'h0);
      check("reset_jcnt",    jump_count_out,         32'h0);
      drive(0, 0, 0, 0, 0, 32'h0);
      #9;
      reset_in = 1'b0;
      tick();

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].r_if, vecs[i].r_id, vecs[i].r_exe, vecs[i].r_mem,
               vecs[i].r_jr, vecs[i].addr);
         #1;
         check($sformatf("v%0d_stall", i),   32'(stall_out),         32'(vecs[i].e_stall));
         check($sformatf("v%0d_flush", i),   32'(jump_flush_out),    32'(vecs[i].e_flush));
         check($sformatf("v%0d_jump", i),    32'(jump_out),          32'(vecs[i].e_jump));
         check($sformatf("v%0d_addr", i),    jump_addr_out,          vecs[i].e_addr);
         check($sformatf("v%0d_timeout", i), 32'(stall_timeout_out), 32'(vecs[i].e_to));
         tick();
      end

      check("perf_stall_cycles", stall_cycles_out, exp_stall_cycles);
      check("perf_jump_count",   jump_count_out,   exp_jump_count);

      // jump deferred by a MEM stall, then reset while still pending
      drive(0, 0, 0, 1, 1, 32'h500);
      #1;
      check("pend_entry_stall", 32'(stall_out), 32'h1f);
      tick();
      drive(0, 0, 0, 1, 0, 32'h0);
      #1;
      check("pend_stall",   32'(stall_out),         32'h1f);
      check("pend_jump",    32'(jump_out),          32'h0);
      check("pend_addr",    jump_addr_out,          32'h500);
      check("pend_timeout", 32'(stall_timeout_out), 32'h1);
      #2;
      reset_in = 1'b1;
      #1;
      check("rst_pend_stall",   32'(stall_out),         32'h0);
      check("rst_pend_flush",   32'(jump_flush_out),    32'h0);
      check("rst_pend_jump",    32'(jump_out),          32'h0);
      check("rst_pend_addr",    jump_addr_out,          32'h0);
      check("rst_pend_timeout", 32'(stall_timeout_out), 32'h0);
      check("rst_pend_jcnt",    jump_count_out,         32'h0);
      tick();
      reset_in = 1'b0;
      drive(0, 0, 0, 0, 0, 32'h0);
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("post_rst%0d_jump", k),  32'(jump_out),       32'h0);
         check($sformatf("post_rst%0d_flush", k), 32'(jump_flush_out), 32'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
